// File: rtl/divider_reconstructor.sv
// Shift-add inverse of the 32/16 restoring divider: p = q*b + r, with fit and r>=b flags.
// Latency BW+1 edges from accepted start to ready; start is ignored while busy, nothing is queued.
module divider_reconstructor #(
   parameter int QW = 32,
   parameter int BW = 16,
   parameter int CW = 5
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             start,
   input  logic [QW-1:0]    q,
   input  logic [BW-1:0]    b,
   input  logic [BW-1:0]    r,
   output logic [QW+BW-1:0] p,
   output logic             fits,
   output logic             rem_err,
   output logic             busy,
   output logic             ready,
   output logic [CW-1:0]    counter
);

   localparam int PW = QW + BW;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state;
   logic [PW-1:0] mq;
   logic [BW-1:0] mb;
   logic [PW-1:0] acc;
   logic [PW-1:0] acc_next;
   logic          last_iter;

   // The final iteration's partial add must land in p, so completion uses acc_next.
   always_comb begin
      acc_next  = mb[0] ? (acc + mq) : acc;
      last_iter = (counter == CW'(BW - 1));
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state   <= S_IDLE;
         mq      <= '0;
         mb      <= '0;
         acc     <= '0;
         p       <= '0;
         fits    <= 1'b1;
         rem_err <= 1'b0;
         busy    <= 1'b0;
         ready   <= 1'b0;
         counter <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  mq      <= {{BW{1'b0}}, q};
                  mb      <= b;
                  acc     <= {{QW{1'b0}}, r};
                  rem_err <= (r >= b);
                  counter <= '0;
                  busy    <= 1'b1;
                  ready   <= 1'b0;
                  state   <= S_RUN;
               end
            end
            S_RUN: begin
               acc     <= acc_next;
               mq      <= mq << 1;
               mb      <= mb >> 1;
               counter <= counter + CW'(1);
               if (last_iter) begin
                  p     <= acc_next;
                  fits  <= (acc_next[PW-1:QW] == '0);
                  busy  <= 1'b0;
                  ready <= 1'b1;
                  state <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_divider_reconstructor.sv
// Bench for divider_reconstructor: vector table plus timing corner sequences, checked by a result scoreboard.
module tb_divider_reconstructor;

   logic        clk = 1'b0;
   logic        clear;
   logic        start;
   logic [31:0] q;
   logic [15:0] b;
   logic [15:0] r;
   logic [47:0] p;
   logic        fits;
   logic        rem_err;
   logic        busy;
   logic        ready;
   logic [4:0]  counter;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [47:0] p;
      logic        fits;
      logic        rem;
   } exp_t;

   typedef struct {
      logic [31:0] q;
      logic [15:0] b;
      logic [15:0] r;
      logic [47:0] p;
      logic        fits;
      logic        rem;
   } vec_t;

   exp_t exp_q[$];
   vec_t vecs[8];
   logic ready_q = 1'b0;

   divider_reconstructor #(.QW(32), .BW(16), .CW(5)) dut (
      .clk(clk), .clear(clear), .start(start), .q(q), .b(b), .r(r),
      .p(p), .fits(fits), .rem_err(rem_err), .busy(busy), .ready(ready), .counter(counter)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic logic [47:0] model(input logic [31:0] mq, input logic [15:0] mb, input logic [15:0] mr);
      return 48'(mq) * 48'(mb) + 48'(mr);
   endfunction

   // Scoreboard: each rising ready retires the oldest accepted operation.
   always @(negedge clk) begin
      if (ready && !ready_q) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_ready", 64'(ready), 64'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_p", 64'(p), 64'(e.p));
            chk("sb_fits", 64'(fits), 64'(e.fits));
            chk("sb_rem_err", 64'(rem_err), 64'(e.rem));
            chk("sb_counter", 64'(counter), 64'd16);
         end
      end
      if (busy === 1'b1 && ready === 1'b1)
         chk("busy_and_ready", 64'd1, 64'd0);
      ready_q = ready;
   end

   // Called at a negedge; returns at the negedge just after the accept edge.
   task automatic start_op(input logic [31:0] qq, input logic [15:0] bb, input logic [15:0] rr,
                           input logic [47:0] ep, input logic ef, input logic er);
      exp_t e;
      q = qq; b = bb; r = rr; start = 1'b1;
      e.p = ep; e.fits = ef; e.rem = er;
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic start_model(input logic [31:0] qq, input logic [15:0] bb, input logic [15:0] rr);
      logic [47:0] mp;
      mp = model(qq, bb, rr);
      start_op(qq, bb, rr, mp, (mp[47:32] == 16'd0), (rr >= bb));
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (ready !== 1'b1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      if (ready !== 1'b1)
         chk("ready_timeout", 64'(ready), 64'd1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_p"}, 64'(p), 64'd0);
      chk({tag, "_fits"}, 64'(fits), 64'd1);
      chk({tag, "_rem_err"}, 64'(rem_err), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_ready"}, 64'(ready), 64'd0);
      chk({tag, "_counter"}, 64'(counter), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;

      vecs[0] = '{32'h0001_0000, 16'h6A0E, 16'h0005, 48'h0000_6A0E_0005, 1'b1, 1'b0};
      vecs[1] = '{32'hFFFF_FFFF, 16'hFFFF, 16'hFFFE, 48'hFFFE_FFFF_FFFF, 1'b0, 1'b0};
      vecs[2] = '{32'h0000_0003, 16'h0004, 16'h0004, 48'h0000_0000_0010, 1'b1, 1'b1};
      vecs[3] = '{32'hDEAD_BEEF, 16'h0000, 16'h1234, 48'h0000_0000_1234, 1'b1, 1'b1};
      vecs[4] = '{32'h0000_0000, 16'h0007, 16'h0003, 48'h0000_0000_0003, 1'b1, 1'b0};
      vecs[5] = '{32'h1234_5678, 16'h0001, 16'h0000, 48'h0000_1234_5678, 1'b1, 1'b0};
      vecs[6] = '{32'h8000_0000, 16'h0002, 16'h0001, 48'h0001_0000_0001, 1'b0, 1'b0};
      vecs[7] = '{32'h0000_FFFF, 16'h0001, 16'hFFFF, 48'h0000_0001_FFFE, 1'b1, 1'b1};

      clear = 1'b1; start = 1'b0; q = '0; b = '0; r = '0;
      repeat (2) @(negedge clk);
      chk_reset_vals("reset");
      clear = 1'b0;
      @(negedge clk);
      chk_reset_vals("idle");

      // Basic op with per-cycle handshake and held p.
      start_op(32'h0001_0000, 16'h6A0E, 16'h0005, 48'h0000_6A0E_0005, 1'b1, 1'b0);
      chk("e0_busy", 64'(busy), 64'd1);
      chk("e0_counter", 64'(counter), 64'd0);
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         chk($sformatf("run_counter_%0d", k), 64'(counter), 64'(k));
         chk($sformatf("run_busy_%0d", k), 64'(busy), 64'(k < 16));
         chk($sformatf("run_ready_%0d", k), 64'(ready), 64'(k == 16));
         if (k < 16) chk($sformatf("run_p_held_%0d", k), 64'(p), 64'd0);
      end
      @(negedge clk);
      chk("done_hold_p", 64'(p), 64'h0000_6A0E_0005);
      chk("done_hold_ready", 64'(ready), 64'd1);
      chk("done_hold_counter", 64'(counter), 64'd16);

      // Table vectors, issued back-to-back on the first DONE cycle.
      for (int i = 0; i < 8; i++) begin
         start_op(vecs[i].q, vecs[i].b, vecs[i].r, vecs[i].p, vecs[i].fits, vecs[i].rem);
         chk($sformatf("vec%0d_accept_ready", i), 64'(ready), 64'd0);
         chk($sformatf("vec%0d_accept_busy", i), 64'(busy), 64'd1);
         wait_done(cyc);
         chk($sformatf("vec%0d_latency", i), 64'(cyc), 64'd16);
      end

      // Start during busy must be ignored; operand changes after accept have no effect.
      start_model(32'h0000_1111, 16'h0123, 16'h0011);
      q = 32'hCAFE_F00D; b = 16'h0F0F; r = 16'h0101;
      repeat (4) @(negedge clk);
      start = 1'b1; q = 32'hFFFF_FFFF; b = 16'hFFFF; r = 16'h0000;
      @(negedge clk);
      start = 1'b0;
      chk("ignore_counter", 64'(counter), 64'd5);
      wait_done(cyc);
      chk("ignore_latency", 64'(cyc), 64'd11);

      // Back-to-back on the first DONE cycle.
      start_model(32'h0BAD_CAFE, 16'h7FFF, 16'h1000);
      chk("b2b_ready_drop", 64'(ready), 64'd0);
      wait_done(cyc);
      chk("b2b_latency", 64'(cyc), 64'd16);

      // Clear mid-operation aborts with no result.
      @(negedge clk);
      start_model(32'h5555_AAAA, 16'h3333, 16'h0042);
      repeat (7) @(negedge clk);
      chk("pre_clear_counter", 64'(counter), 64'd7);
      clear = 1'b1;
      void'(exp_q.pop_back());
      @(negedge clk);
      clear = 1'b0;
      chk_reset_vals("midclear");
      repeat (3) @(negedge clk);
      chk("post_clear_ready", 64'(ready), 64'd0);
      start_model(32'h5555_AAAA, 16'h3333, 16'h0042);
      wait_done(cyc);
      chk("post_clear_latency", 64'(cyc), 64'd16);

      // Random operands against the arithmetic model.
      for (int i = 0; i < 20; i++) begin
         logic [31:0] rq;
         logic [15:0] rb;
         logic [15:0] rr;
         rq = $urandom();
         rb = 16'($urandom_range(0, 65535));
         rr = (i % 3 == 0) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 32767)) % (rb | 16'h1);
         start_model(rq, rb, rr);
         wait_done(cyc);
      end

      @(negedge clk);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/divider_reconstructor.md
Name: divider_reconstructor

Overview:
- Sequential shift-add multiplier that rebuilds a dividend from the outputs of the 32/16 restoring divider: p = q*b + r.
- Sits behind the divider as its inverse datapath. Consumes the divider's quotient, divisor and remainder, and flags results that are inconsistent or do not fit 32 bits.
- Used in self-check paths and in bench scoreboards.
- Same start/busy/ready/counter handshake style as the divider.

Parameters:
- QW, 32, quotient width; dividend width.
- BW, 16, divisor/remainder width; sets the iteration count.
- CW, 5, counter width; must hold the value BW.

Ports:
- clk  input  1  rising-edge clock
- clear  input  1  synchronous reset, active-high
- start  input  1  request; sampled only when idle
- q  input  QW  quotient operand
- b  input  BW  divisor operand (multiplier bits)
- r  input  BW  remainder operand
- p  output  QW+BW  reconstructed dividend q*b+r
- fits  output  1  p[QW+BW-1:QW]==0, i.e. result fits the dividend width
- rem_err  output  1  r >= b, captured at start (covers b==0)
- busy  output  1  iteration in progress
- ready  output  1  result valid, level
- counter  output  CW  iterations completed in current/last operation

Behaviour:
- Reset (clear=1 at clk edge):
  - p=0, fits=1, rem_err=0, busy=0, ready=0, counter=0.
  - Internal shift registers are cleared; FSM goes to IDLE.
  - clear has priority over everything. Asserting it mid-operation aborts the operation with no result.
- FSM states: IDLE, RUN, DONE.
  - DONE behaves as IDLE, except ready=1.
- Accept (IDLE or DONE, start=1) at edge E0:
  - mq <= zero-extended q (QW+BW bits); mb <= b; acc <= zero-extended r.
  - rem_err <= (r >= b); counter <= 0; busy <= 1; ready <= 0.
  - Go to RUN.
  - Operands are sampled only at E0. Later changes on q/b/r are ignored.
- RUN, each edge E1..E16 (BW iterations):
  - If mb[0], acc <= acc + mq. The add is QW+BW bits wide, never overflows, no carry out is kept.
  - mq <= mq << 1; mb <= mb >> 1; counter <= counter + 1.
- Completion, on the edge where counter goes BW-1 -> BW (E16):
  - p <= final acc, including that edge's partial add.
  - fits <= (upper BW bits of the final acc == 0).
  - busy <= 0; ready <= 1; go to DONE.
  - Latency: start sampled at E0, ready high after E16, i.e. BW+1 edges.
- In DONE:
  - p, fits, rem_err and ready are held; counter holds BW.
  - A new start is accepted exactly as in IDLE; ready drops at that accept edge.
- start while busy=1 is ignored; no queueing.
- busy and ready are never both 1.
- p only updates at completion. During RUN it keeps the previous result (or 0 after reset).
- b==0: all iterations add nothing; p = r; rem_err=1.
- q==0: p = r.
- Maximum operands cannot overflow p: (2^32-1)(2^16-1)+(2^16-1) < 2^48.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset, then idle: clear=1 for 2 cycles, start=0 → p=0, fits=1, rem_err=0, busy=0, ready=0, counter=0.
- Basic: q=0x00010000, b=0x6A0E, r=0x0005, 1-cycle start pulse → busy for 16 cycles, counter steps 0..16, ready after E16, p=0x00006A0E0005, fits=1, rem_err=0.
- Max operands: q=0xFFFFFFFF, b=0xFFFF, r=0xFFFE → p=0xFFFEFFFFFFFF, fits=0, rem_err=0.
- Inconsistent remainder: q=3, b=4, r=4 → p=0x10, fits=1, rem_err=1. Then b=0, r=0x1234, q=0xDEADBEEF → p=0x1234, rem_err=1.
- Busy ignore and back-to-back:
  - Start op A, pulse start again with new operands at E5 → A completes unchanged at E16.
  - Start op B on the first DONE cycle → ready drops at that accept edge, B's result appears 17 edges later.
- Clear mid-op: start at E0, clear=1 at E8 → next cycle all outputs at reset values. A following start runs a full 16-iteration operation with correct p.
